turbo_arbiter: RTL and testbench
================================

TURBO_ARBITER -- requirements
Module: turbo_arbiter

Interface
REQ-001 Parameter FE_HOLDOFF, default 4095, shall set the ck35 ticks the port #FE hold-off stays active after the last #FE access (12-bit range).
REQ-002 Parameter DWELL, default 16, shall set the minimum ck35 ticks between two committed turbo changes (5-bit range, 1..31).
REQ-003 clk28  input  1  system clock, 28 MHz; sole clock.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ck35  input  1  one-clk28-wide strobe at 3.5 MHz rate.
REQ-006 bus  input  cpu_bus  shared CPU bus; only mreq, ioreq, a[0] are used.
REQ-007 turbo_cfg  input  3  user-selected turbo: 0 NONE, 1 T7, 2 T14, 3 MAX; 4..7 reserved.
REQ-008 autoturbo_en  input  1  enables automatic turbo selection.
REQ-009 div_paged  input  1  DivMMC ROM currently paged in.
REQ-010 magic_map  input  1  magic ROM currently mapped.
REQ-011 force_slow  input  1  external demand for NONE (tape/timing-critical).
REQ-012 turbo  output  3  committed turbo level driven to the clock generator.
REQ-013 turbo_switch  output  1  one-clk28 pulse on each commit.
REQ-014 pending  output  1  high while a change is waiting to commit.

Function
REQ-015 Target shall be computed combinationally by priority: force_slow -> NONE; else autoturbo_en & div_paged & !magic_map -> T14; else autoturbo_en & fe_active -> NONE; else turbo_cfg, with reserved codes mapped to NONE.
REQ-016 An #FE access (bus.ioreq & !bus.a[0]) shall load the hold-off counter with FE_HOLDOFF; otherwise the counter shall decrement on ck35 while non-zero; fe_active = counter != 0.
REQ-017 A reload and a ck35 in the same clk28 shall leave the counter at FE_HOLDOFF.
REQ-018 The FSM shall have states STABLE, PENDING, DWELL.
REQ-019 STABLE: target != turbo -> PENDING on the next clk28; otherwise remain.
REQ-020 PENDING: if target == turbo -> STABLE with no commit; else on ck35 with !bus.mreq & !bus.ioreq commit turbo <= target, pulse turbo_switch, load the dwell counter with DWELL, -> DWELL.
REQ-021 A commit shall load the target value sampled in the commit cycle, not the value that caused entry to PENDING.
REQ-022 PENDING shall wait indefinitely while the bus stays busy on every ck35.
REQ-023 DWELL: decrement on ck35; at 0 -> STABLE; target changes during DWELL shall not alter turbo.
REQ-024 Latency from a target change in STABLE to commit shall be at least 2 clk28, and at most the next idle ck35 after entering PENDING.
REQ-025 pending shall be 1 exactly in PENDING, and in DWELL when target != turbo.

Reset
REQ-026 While rst is high, on each clk28 edge: turbo = NONE, turbo_switch = 0, state = STABLE, hold-off counter = 0, dwell counter = 0.
REQ-027 Reset asserted in PENDING or DWELL shall abandon the change with no turbo_switch pulse.
REQ-028 After rst deasserts, a non-NONE target shall follow the normal STABLE -> PENDING path.

Configuration
REQ-029 Macro AUTOTURBO_FE_HOLDOFF_EN: when defined, the REQ-016/017 hold-off counter shall be implemented.
REQ-030 When AUTOTURBO_FE_HOLDOFF_EN is undefined, fe_active shall be constant 0, no counter shall be synthesised, and #FE accesses shall have no effect.

Verification
REQ-031 Reset, turbo_cfg=2, bus idle -> turbo=2 on the first idle ck35 after PENDING; a single turbo_switch pulse.
REQ-032 turbo=0, turbo_cfg 0->2->0 within one ck35 period -> no commit, FSM returns to STABLE, turbo_switch stays 0.
REQ-033 autoturbo_en=1, turbo_cfg=3, #FE read -> turbo=0 after an idle ck35; turbo returns to 3 only after FE_HOLDOFF ck35 ticks with no further #FE access (ifdef build).
REQ-034 autoturbo_en=1, div_paged=1, magic_map=0, force_slow=1 -> turbo=0; release force_slow -> turbo=2.
REQ-035 Two commits requested back to back -> spacing >= DWELL ck35 ticks; second commit takes the target value at commit time.
REQ-036 bus.mreq held high for 5 ck35 ticks while PENDING -> no commit until the first ck35 with the bus idle; rst pulse in PENDING -> turbo=0, no turbo_switch pulse.

Source files
------------

// File: rtl/turbo_arbiter_if.sv
// cpu_bus: shared CPU bus bundle. Observers such as turbo_arbiter
// only look at it through the monitor modport.
interface cpu_bus;
    logic        mreq;
    logic        ioreq;
    logic [15:0] a;

    modport monitor (input mreq, input ioreq, input a);
endinterface

// File: rtl/turbo_arbiter.sv
// turbo_arbiter: chooses the CPU turbo level and commits changes to the
// clock generator only on an idle ck35 strobe, with a minimum dwell
// between commits.
//
// Optional feature: define AUTOTURBO_FE_HOLDOFF_EN to build the port #FE
// hold-off counter that forces NONE while autoturbo is on and the ULA
// port was touched recently. Without the macro, fe_active is tied low
// and #FE accesses have no effect.
module turbo_arbiter #(
    parameter logic [11:0] FE_HOLDOFF = 12'd4095,
    parameter logic [4:0]  DWELL      = 5'd16
) (
    input  logic       clk28,
    input  logic       rst,
    input  logic       ck35,
    cpu_bus.monitor    bus,
    input  logic [2:0] turbo_cfg,
    input  logic       autoturbo_en,
    input  logic       div_paged,
    input  logic       magic_map,
    input  logic       force_slow,
    output logic [2:0] turbo,
    output logic       turbo_switch,
    output logic       pending
);

    localparam logic [2:0] TURBO_NONE = 3'd0;
    localparam logic [2:0] TURBO_T14  = 3'd2;

    localparam logic [1:0] ST_STABLE  = 2'd0;
    localparam logic [1:0] ST_PENDING = 2'd1;
    localparam logic [1:0] ST_DWELL   = 2'd2;

    logic [1:0] state;
    logic [4:0] dwell_cnt;
    logic [2:0] target;
    logic       fe_active;
    logic       bus_idle;
    logic       unused_bus;

    assign bus_idle = !bus.mreq && !bus.ioreq;

`ifdef AUTOTURBO_FE_HOLDOFF_EN
    logic [11:0] holdoff_cnt;
    logic        fe_access;

    assign fe_access  = bus.ioreq && !bus.a[0];
    assign fe_active  = (holdoff_cnt != 12'd0);
    assign unused_bus = ^bus.a[15:1];

    // Hold-off counter: an #FE access reloads it (winning over a same-cycle
    // ck35), otherwise it counts ck35 ticks down to zero.
    always_ff @(posedge clk28) begin
        if (rst) begin
            holdoff_cnt <= 12'd0;
        end else if (fe_access) begin
            holdoff_cnt <= FE_HOLDOFF;
        end else if (ck35 && (holdoff_cnt != 12'd0)) begin
            holdoff_cnt <= holdoff_cnt - 12'd1;
        end
    end
`else
    assign fe_active  = 1'b0;
    assign unused_bus = ^{bus.a, FE_HOLDOFF};
`endif

    // Desired turbo level: slow demands first, then DivMMC boost, then
    // #FE hold-off, then the user setting with reserved codes as NONE.
    always_comb begin
        target = turbo_cfg[2] ? TURBO_NONE : turbo_cfg;
        if (force_slow) begin
            target = TURBO_NONE;
        end else if (autoturbo_en && div_paged && !magic_map) begin
            target = TURBO_T14;
        end else if (autoturbo_en && fe_active) begin
            target = TURBO_NONE;
        end
    end

    // Commit FSM: notice a mismatch, wait for an idle ck35 to switch, then
    // hold the new level for DWELL ck35 ticks before looking again.
    always_ff @(posedge clk28) begin
        if (rst) begin
            state        <= ST_STABLE;
            turbo        <= TURBO_NONE;
            turbo_switch <= 1'b0;
            dwell_cnt    <= 5'd0;
        end else begin
            turbo_switch <= 1'b0;
            case (state)
                ST_STABLE: begin
                    if (target != turbo) begin
                        state <= ST_PENDING;
                    end
                end
                ST_PENDING: begin
                    if (target == turbo) begin
                        state <= ST_STABLE;
                    end else if (ck35 && bus_idle) begin
                        turbo        <= target;
                        turbo_switch <= 1'b1;
                        dwell_cnt    <= DWELL;
                        state        <= ST_DWELL;
                    end
                end
                ST_DWELL: begin
                    if (dwell_cnt == 5'd0) begin
                        state <= ST_STABLE;
                    end else if (ck35) begin
                        dwell_cnt <= dwell_cnt - 5'd1;
                    end
                end
                default: begin
                    state <= ST_STABLE;
                end
            endcase
        end
    end

    assign pending = (state == ST_PENDING) ||
                     ((state == ST_DWELL) && (target != turbo));

endmodule

// File: tb/tb_turbo_arbiter.sv
// tb_turbo_arbiter: directed scenarios plus randomized stimulus for
// turbo_arbiter, checked every cycle against a tick-counting model.
// Honours AUTOTURBO_FE_HOLDOFF_EN the same way the design does.
module tb_turbo_arbiter;

    localparam int FE_HOLD = 20;
    localparam int DWELL_T = 4;
    localparam int CAP     = 1000000;

    localparam int PH_AGREE  = 0;
    localparam int PH_WAIT   = 1;
    localparam int PH_SETTLE = 2;

    logic       clk28 = 1'b0;
    logic       rst;
    logic       ck35;
    logic [2:0] turbo_cfg;
    logic       autoturbo_en;
    logic       div_paged;
    logic       magic_map;
    logic       force_slow;
    logic [2:0] turbo;
    logic       turbo_switch;
    logic       pending;

    cpu_bus bus_if ();

    turbo_arbiter #(
        .FE_HOLDOFF (12'(FE_HOLD)),
        .DWELL      (5'(DWELL_T))
    ) dut (
        .clk28        (clk28),
        .rst          (rst),
        .ck35         (ck35),
        .bus          (bus_if),
        .turbo_cfg    (turbo_cfg),
        .autoturbo_en (autoturbo_en),
        .div_paged    (div_paged),
        .magic_map    (magic_map),
        .force_slow   (force_slow),
        .turbo        (turbo),
        .turbo_switch (turbo_switch),
        .pending      (pending)
    );

    always #5 clk28 = ~clk28;

    int checks       = 0;
    int errors       = 0;
    bit check_en     = 1'b0;
    int ck_phase     = 0;
    int tick_num     = 0;
    int switch_count = 0;

    // Model state, expressed as ck35 tick distances rather than counters.
    int m_turbo        = 0;
    bit m_switch       = 1'b0;
    int m_phase        = PH_AGREE;
    int since_commit   = 0;
    int since_fe       = CAP;

    // ck35 strobe: one clk28 in eight, updated just after the edge.
    always @(posedge clk28) begin
        #1;
        ck_phase = (ck_phase + 1) % 8;
        ck35 = (ck_phase == 0);
    end

    function automatic int modelTarget();
        bit fe_busy;
`ifdef AUTOTURBO_FE_HOLDOFF_EN
        fe_busy = (since_fe < FE_HOLD);
`else
        fe_busy = 1'b0;
`endif
        if (force_slow) return 0;
        if (autoturbo_en && div_paged && !magic_map) return 2;
        if (autoturbo_en && fe_busy) return 0;
        if (turbo_cfg > 3'd3) return 0;
        return int'(turbo_cfg);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model advance at each clock edge.
    always @(posedge clk28) begin
        int  tgt;
        bit  idle;
        tgt  = modelTarget();
        idle = !bus_if.mreq && !bus_if.ioreq;
        if (ck35) tick_num++;
        if (rst) begin
            m_turbo      = 0;
            m_switch     = 1'b0;
            m_phase      = PH_AGREE;
            since_commit = 0;
            since_fe     = CAP;
        end else begin
            m_switch = 1'b0;
            if (m_phase == PH_AGREE) begin
                if (tgt != m_turbo) m_phase = PH_WAIT;
            end else if (m_phase == PH_WAIT) begin
                if (tgt == m_turbo) begin
                    m_phase = PH_AGREE;
                end else if (ck35 && idle) begin
                    m_turbo      = tgt;
                    m_switch     = 1'b1;
                    since_commit = 0;
                    m_phase      = PH_SETTLE;
                end
            end else begin
                if (since_commit >= DWELL_T) m_phase = PH_AGREE;
                else if (ck35) since_commit++;
            end
            if (bus_if.ioreq && !bus_if.a[0]) since_fe = 0;
            else if (ck35 && since_fe < CAP) since_fe++;
        end
    end

    // Compare DUT outputs against the model mid-cycle.
    always @(negedge clk28) begin
        if (check_en) begin
            int tgt;
            bit m_pend;
            tgt    = modelTarget();
            m_pend = (m_phase == PH_WAIT) || (m_phase == PH_SETTLE && tgt != m_turbo);
            checkOutput("model_turbo", 32'(turbo), 32'(m_turbo));
            checkOutput("model_switch", 32'(turbo_switch), 32'(m_switch));
            checkOutput("model_pending", 32'(pending), 32'(m_pend));
        end
        if (turbo_switch === 1'b1) switch_count++;
    end

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(posedge clk28);
            #2;
        end
    endtask

    task automatic applyStimulus(input bit r, input logic [2:0] cfg, input bit au,
                                 input bit dv, input bit mg, input bit fs,
                                 input bit mq, input bit io, input logic [15:0] addr);
        rst          = r;
        turbo_cfg    = cfg;
        autoturbo_en = au;
        div_paged    = dv;
        magic_map    = mg;
        force_slow   = fs;
        bus_if.mreq  = mq;
        bus_if.ioreq = io;
        bus_if.a     = addr;
        stepCycles(1);
    endtask

    task automatic waitSwitch(input string name, input int budget);
        int start = switch_count;
        int n     = 0;
        while (switch_count == start && n < budget) begin
            stepCycles(1);
            n++;
        end
        checks++;
        if (switch_count == start) begin
            errors++;
            $display("[TB] FAIL %s: no turbo_switch within %0d cycles, got 0 pulses, expected 1", name, budget);
        end
    endtask

    task automatic waitTick();
        int n = 0;
        while (ck35 !== 1'b1 && n < 16) begin
            stepCycles(1);
            n++;
        end
        checks++;
        if (ck35 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ck35_seen: got %b, expected 1", ck35);
        end
    endtask

    task automatic settle();
        stepCycles(8 * DWELL_T + 24);
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int t0;
        int t1;
        int t2;
        int n;

        ck35 = 1'b0;
        applyStimulus(1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        stepCycles(2);
        check_en = 1'b1;

        // Reset holds everything idle even with a turbo request present.
        turbo_cfg = 3'd2;
        stepCycles(2);
        checkOutput("reset_turbo", 32'(turbo), 32'd0);
        checkOutput("reset_switch", 32'(turbo_switch), 32'd0);
        checkOutput("reset_pending", 32'(pending), 32'd0);

        // First commit after reset: single pulse, turbo becomes T14.
        base = switch_count;
        rst  = 1'b0;
        waitSwitch("first_commit", 40);
        checkOutput("first_commit_turbo", 32'(turbo), 32'd2);
        settle();
        checkOutput("first_commit_pulses", 32'(switch_count - base), 32'd1);

        // Short-lived request between ck35 strobes never commits.
        turbo_cfg = 3'd0;
        rst = 1'b1;
        stepCycles(2);
        rst = 1'b0;
        stepCycles(4);
        waitTick();
        stepCycles(1);
        base = switch_count;
        turbo_cfg = 3'd2;
        stepCycles(2);
        turbo_cfg = 3'd0;
        stepCycles(20);
        checkOutput("glitch_no_switch", 32'(switch_count - base), 32'd0);
        checkOutput("glitch_turbo", 32'(turbo), 32'd0);
        checkOutput("glitch_pending", 32'(pending), 32'd0);

        // force_slow overrides DivMMC boost; releasing it yields T14.
        autoturbo_en = 1'b1;
        div_paged    = 1'b1;
        magic_map    = 1'b0;
        force_slow   = 1'b1;
        base = switch_count;
        stepCycles(24);
        checkOutput("force_slow_turbo", 32'(turbo), 32'd0);
        checkOutput("force_slow_no_switch", 32'(switch_count - base), 32'd0);
        force_slow = 1'b0;
        waitSwitch("force_release", 40);
        checkOutput("force_release_turbo", 32'(turbo), 32'd2);
        settle();

        // #FE access with autoturbo drops to NONE until the hold-off expires.
        rst = 1'b1;
        div_paged = 1'b0;
        turbo_cfg = 3'd3;
        stepCycles(2);
        rst = 1'b0;
        waitSwitch("fe_setup", 40);
        checkOutput("fe_setup_turbo", 32'(turbo), 32'd3);
        settle();
        base = switch_count;
        bus_if.ioreq = 1'b1;
        bus_if.a     = 16'h00FE;
        stepCycles(1);
        bus_if.ioreq = 1'b0;
        bus_if.a     = 16'h0000;
        t0 = tick_num;
`ifdef AUTOTURBO_FE_HOLDOFF_EN
        waitSwitch("fe_slow", 40);
        checkOutput("fe_slow_turbo", 32'(turbo), 32'd0);
        stepCycles(80);
        checkOutput("fe_holdoff_turbo", 32'(turbo), 32'd0);
        waitSwitch("fe_release", 8 * FE_HOLD + 60);
        checkOutput("fe_release_turbo", 32'(turbo), 32'd3);
        checkOutput("fe_release_ticks_ok", 32'((tick_num - t0) >= FE_HOLD), 32'd1);
`else
        stepCycles(40);
        checkOutput("fe_ignored_turbo", 32'(turbo), 32'd3);
        checkOutput("fe_ignored_switch", 32'(switch_count - base), 32'd0);
`endif
        settle();

        // Back-to-back requests: dwell spacing and commit-time target.
        autoturbo_en = 1'b0;
        stepCycles(4);
        turbo_cfg = 3'd1;
        waitSwitch("b2b_first", 40);
        t1 = tick_num;
        checkOutput("b2b_first_turbo", 32'(turbo), 32'd1);
        turbo_cfg = 3'd2;
        stepCycles(8);
        turbo_cfg = 3'd3;
        waitSwitch("b2b_second", 8 * DWELL_T + 60);
        t2 = tick_num;
        checkOutput("b2b_spacing", 32'(t2 - t1), 32'(DWELL_T + 1));
        checkOutput("b2b_second_turbo", 32'(turbo), 32'd3);
        settle();

        // Busy bus blocks the commit until the first idle ck35.
        bus_if.mreq = 1'b1;
        turbo_cfg   = 3'd1;
        stepCycles(2);
        checkOutput("busy_pending", 32'(pending), 32'd1);
        base = switch_count;
        t0 = tick_num;
        n = 0;
        while ((tick_num - t0) < 5 && n < 80) begin
            stepCycles(1);
            n++;
        end
        checkOutput("busy_ticks_seen", 32'(tick_num - t0), 32'd5);
        checkOutput("busy_no_switch", 32'(switch_count - base), 32'd0);
        checkOutput("busy_turbo", 32'(turbo), 32'd3);
        bus_if.mreq = 1'b0;
        t0 = tick_num;
        waitSwitch("busy_release", 20);
        checkOutput("busy_release_tick", 32'(tick_num - t0), 32'd1);
        checkOutput("busy_release_turbo", 32'(turbo), 32'd1);
        settle();

        // Reset while a change is pending abandons it silently.
        bus_if.mreq = 1'b1;
        turbo_cfg   = 3'd2;
        stepCycles(3);
        checkOutput("rst_pend_pending", 32'(pending), 32'd1);
        base = switch_count;
        rst = 1'b1;
        stepCycles(2);
        checkOutput("rst_pend_turbo", 32'(turbo), 32'd0);
        bus_if.mreq = 1'b0;
        turbo_cfg   = 3'd0;
        rst = 1'b0;
        stepCycles(20);
        checkOutput("rst_pend_no_switch", 32'(switch_count - base), 32'd0);
        checkOutput("rst_pend_turbo_after", 32'(turbo), 32'd0);

        // Randomized traffic, checked every cycle by the model.
        for (int i = 0; i < 4000; i++) begin
            logic [2:0]  cfg;
            logic [15:0] addr;
            bit          io;
            cfg = turbo_cfg;
            if ($urandom_range(19) == 0) cfg = 3'($urandom_range(7));
            if ($urandom_range(99) == 0) autoturbo_en = ~autoturbo_en;
            if ($urandom_range(59) == 0) div_paged = ~div_paged;
            if ($urandom_range(59) == 0) magic_map = ~magic_map;
            if ($urandom_range(79) == 0) force_slow = ~force_slow;
            io   = ($urandom_range(5) == 0);
            addr = 16'($urandom);
            if (io && !addr[0] && $urandom_range(15) != 0) addr[0] = 1'b1;
            applyStimulus(($urandom_range(199) == 0), cfg, autoturbo_en, div_paged,
                          magic_map, force_slow, ($urandom_range(2) == 0), io, addr);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
